// File: rtl/sseg_capture.sv
// Recovers per-digit BCD values from a multiplexed, active-low seven-segment bus.
// A digit commits only after its anode/segment sample has been stable for STABLE_CYCLES edges.
module sseg_capture #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_DIGITS-1:0]     an,
    input  logic [6:0]                sseg,
    input  logic                      err_clr,
    output logic [4*NUM_DIGITS-1:0]   bcd_out,
    output logic [NUM_DIGITS-1:0]     digit_valid,
    output logic                      upd,
    output logic [2:0]                upd_idx,
    output logic                      err
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, TRACK, HOLD} state_t;

    function automatic logic one_low(input logic [NUM_DIGITS-1:0] a);
        int zeros;
        zeros = 0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (!a[i]) zeros++;
        return (zeros == 1);
    endfunction

    function automatic logic [2:0] low_idx(input logic [NUM_DIGITS-1:0] a);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (!a[i]) idx = 3'(i);
        return idx;
    endfunction

    // Result packing: {legal, blank, bcd[3:0]}
    function automatic logic [5:0] decode(input logic [6:0] s);
        logic [5:0] r;
        case (s)
            7'b0000001: r = {2'b10, 4'd0};
            7'b1001111: r = {2'b10, 4'd1};
            7'b0010010: r = {2'b10, 4'd2};
            7'b0000110: r = {2'b10, 4'd3};
            7'b1001100: r = {2'b10, 4'd4};
            7'b0100100: r = {2'b10, 4'd5};
            7'b0100000: r = {2'b10, 4'd6};
            7'b0001111: r = {2'b10, 4'd7};
            7'b0000000: r = {2'b10, 4'd8};
            7'b0001100: r = {2'b10, 4'd9};
            7'b1111111: r = {2'b01, 4'hF};
            default:    r = {2'b00, 4'hF};
        endcase
        return r;
    endfunction

    logic [NUM_DIGITS-1:0] an_p0;
    logic [6:0]            sseg_p0;
    state_t                state;
    logic [CNT_W-1:0]      count;

    logic       same;
    logic       new_one;
    logic       commit;
    logic [5:0] dec;
    logic       dec_legal;
    logic       dec_blank;
    logic [3:0] dec_bcd;
    logic [2:0] idx;

    assign same      = (an == an_p0) && (sseg == sseg_p0);
    assign new_one   = one_low(an);
    assign commit    = (state == TRACK) && (count == CNT_W'(STABLE_CYCLES));
    assign dec       = decode(sseg_p0);
    assign dec_legal = dec[5];
    assign dec_blank = dec[4];
    assign dec_bcd   = dec[3:0];
    assign idx       = low_idx(an_p0);

    // Stage p0: sample register, tracking FSM and commit outputs share one edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_p0       <= '1;
            sseg_p0     <= '1;
            state       <= IDLE;
            count       <= '0;
            bcd_out     <= '1;
            digit_valid <= '0;
            upd         <= 1'b0;
            upd_idx     <= 3'd0;
            err         <= 1'b0;
        end else begin
            an_p0   <= an;
            sseg_p0 <= sseg;
            upd     <= commit;

            if (commit) begin
                upd_idx <= idx;
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (idx == 3'(i)) begin
                        if (dec_legal) begin
                            bcd_out[4*i +: 4] <= dec_bcd;
                            digit_valid[i]    <= 1'b1;
                        end else if (dec_blank) begin
                            bcd_out[4*i +: 4] <= 4'hF;
                            digit_valid[i]    <= 1'b0;
                        end
                    end
                end
            end

            // Set has priority over clear so a coincident illegal commit is never lost
            if (commit && !dec_legal && !dec_blank)
                err <= 1'b1;
            else if (err_clr)
                err <= 1'b0;

            case (state)
                IDLE: begin
                    if (new_one) begin
                        state <= TRACK;
                        count <= CNT_W'(1);
                    end
                end
                TRACK: begin
                    if (!same) begin
                        state <= new_one ? TRACK : IDLE;
                        count <= new_one ? CNT_W'(1) : '0;
                    end else if (commit) begin
                        state <= HOLD;
                    end else if (count < CNT_W'(STABLE_CYCLES)) begin
                        count <= count + CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (!same) begin
                        state <= new_one ? TRACK : IDLE;
                        count <= new_one ? CNT_W'(1) : '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    count <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sseg_capture.sv
// Directed bench for sseg_capture with 4 digits and a stability window of 4 samples.
module tb_sseg_capture;

    logic        clk;
    logic        rst_n;
    logic [3:0]  an;
    logic [6:0]  sseg;
    logic        err_clr;
    logic [15:0] bcd_out;
    logic [3:0]  digit_valid;
    logic        upd;
    logic [2:0]  upd_idx;
    logic        err;

    int checks;
    int errors;
    int upd_cnt;

    localparam logic [6:0] P1 = 7'b1001111;
    localparam logic [6:0] P2 = 7'b0010010;
    localparam logic [6:0] P3 = 7'b0000110;
    localparam logic [6:0] P5 = 7'b0100100;
    localparam logic [6:0] P7 = 7'b0001111;
    localparam logic [6:0] P8 = 7'b0000000;
    localparam logic [6:0] P9 = 7'b0001100;
    localparam logic [6:0] PBLANK = 7'b1111111;
    localparam logic [6:0] PBAD1  = 7'b1111110;
    localparam logic [6:0] PBAD2  = 7'b0000010;

    sseg_capture #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .an          (an),
        .sseg        (sseg),
        .err_clr     (err_clr),
        .bcd_out     (bcd_out),
        .digit_valid (digit_valid),
        .upd         (upd),
        .upd_idx     (upd_idx),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (upd === 1'b1) upd_cnt++;

    task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
        an = a;
        sseg = s;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bcd_out !== 16'hFFFF) begin errors++; $display("FAIL reset_bcd got %h want %h", bcd_out, 16'hFFFF); end
        checks++;
        if (digit_valid !== 4'b0000) begin errors++; $display("FAIL reset_valid got %b want %b", digit_valid, 4'b0000); end
        checks++;
        if (err !== 1'b0 || upd !== 1'b0 || upd_idx !== 3'd0) begin
            errors++; $display("FAIL reset_ctl got err=%b upd=%b idx=%0d want 0 0 0", err, upd, upd_idx);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_single;
        upd_cnt = 0;
        hold(4'b1110, P3, 4);
        checks++;
        if (upd !== 1'b0) begin errors++; $display("FAIL single_early got upd=%b want 0", upd); end
        hold(4'b1110, P3, 1);
        checks++;
        if (upd !== 1'b1 || upd_idx !== 3'd0) begin
            errors++; $display("FAIL single_upd got upd=%b idx=%0d want 1 0", upd, upd_idx);
        end
        checks++;
        if (bcd_out[3:0] !== 4'd3 || digit_valid !== 4'b0001) begin
            errors++; $display("FAIL single_data got bcd=%h valid=%b want 3 0001", bcd_out[3:0], digit_valid);
        end
        hold(4'b1110, P3, 1);
        checks++;
        if (upd !== 1'b0 || upd_cnt !== 1) begin
            errors++; $display("FAIL single_pulse got upd=%b count=%0d want 0 1", upd, upd_cnt);
        end
    endtask

    task automatic test_glitch;
        upd_cnt = 0;
        hold(4'b1101, P5, 3);
        hold(4'b1101, P7, 5);
        checks++;
        if (upd !== 1'b1 || upd_idx !== 3'd1) begin
            errors++; $display("FAIL glitch_upd got upd=%b idx=%0d want 1 1", upd, upd_idx);
        end
        hold(4'b1101, P7, 2);
        checks++;
        if (bcd_out[7:0] !== 8'h73 || digit_valid !== 4'b0011) begin
            errors++; $display("FAIL glitch_data got bcd=%h valid=%b want 73 0011", bcd_out[7:0], digit_valid);
        end
        checks++;
        if (upd_cnt !== 1) begin errors++; $display("FAIL glitch_count got %0d want 1", upd_cnt); end
    endtask

    task automatic test_full_scan;
        logic [6:0] pats [4];
        pats[0] = P1; pats[1] = P2; pats[2] = P8; pats[3] = P9;
        upd_cnt = 0;
        for (int r = 0; r < 2; r++)
            for (int d = 0; d < 4; d++)
                hold(~(4'b0001 << d), pats[d], 8);
        checks++;
        if (bcd_out !== 16'h9821 || digit_valid !== 4'b1111) begin
            errors++; $display("FAIL scan_data got bcd=%h valid=%b want 9821 1111", bcd_out, digit_valid);
        end
        checks++;
        if (upd_cnt !== 8) begin errors++; $display("FAIL scan_count got %0d want 8", upd_cnt); end
    endtask

    task automatic test_illegal_blank;
        hold(4'b1011, P5, 5);
        checks++;
        if (bcd_out[11:8] !== 4'd5 || err !== 1'b0) begin
            errors++; $display("FAIL ill_commit5 got bcd=%h err=%b want 5 0", bcd_out[11:8], err);
        end
        hold(4'b1011, PBAD1, 5);
        checks++;
        if (err !== 1'b1 || upd !== 1'b1 || bcd_out[11:8] !== 4'd5 || digit_valid[2] !== 1'b1) begin
            errors++; $display("FAIL ill_bad got err=%b upd=%b bcd=%h valid=%b want 1 1 5 1",
                               err, upd, bcd_out[11:8], digit_valid[2]);
        end
        hold(4'b1011, PBLANK, 5);
        checks++;
        if (bcd_out[11:8] !== 4'hF || digit_valid[2] !== 1'b0 || err !== 1'b1 || upd_idx !== 3'd2) begin
            errors++; $display("FAIL ill_blank got bcd=%h valid=%b err=%b idx=%0d want f 0 1 2",
                               bcd_out[11:8], digit_valid[2], err, upd_idx);
        end
        hold(4'b1011, PBAD2, 4);
        err_clr = 1'b1;
        hold(4'b1011, PBAD2, 1);
        checks++;
        if (err !== 1'b1 || upd !== 1'b1) begin
            errors++; $display("FAIL ill_setwins got err=%b upd=%b want 1 1", err, upd);
        end
        hold(4'b1011, PBAD2, 1);
        err_clr = 1'b0;
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL ill_clear got err=%b want 0", err); end
    endtask

    task automatic test_multi_none;
        upd_cnt = 0;
        hold(4'b1100, P8, 10);
        hold(4'b1111, P1, 10);
        checks++;
        if (upd_cnt !== 0) begin errors++; $display("FAIL multi_count got %0d want 0", upd_cnt); end
        checks++;
        if (bcd_out !== 16'h9F21 || digit_valid !== 4'b1011 || err !== 1'b0) begin
            errors++; $display("FAIL multi_hold got bcd=%h valid=%b err=%b want 9f21 1011 0",
                               bcd_out, digit_valid, err);
        end
    endtask

    task automatic test_reset_mid_track;
        hold(4'b1110, P7, 2);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bcd_out !== 16'hFFFF || digit_valid !== 4'b0000) begin
            errors++; $display("FAIL midrst_clear got bcd=%h valid=%b want ffff 0000", bcd_out, digit_valid);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        upd_cnt = 0;
        hold(4'b1110, P7, 4);
        checks++;
        if (upd_cnt !== 0 || upd !== 1'b0) begin
            errors++; $display("FAIL midrst_early got count=%0d upd=%b want 0 0", upd_cnt, upd);
        end
        hold(4'b1110, P7, 1);
        checks++;
        if (upd !== 1'b1 || bcd_out[3:0] !== 4'd7 || digit_valid !== 4'b0001) begin
            errors++; $display("FAIL midrst_commit got upd=%b bcd=%h valid=%b want 1 7 0001",
                               upd, bcd_out[3:0], digit_valid);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        upd_cnt = 0;
        rst_n   = 1'b1;
        an      = 4'b1111;
        sseg    = PBLANK;
        err_clr = 1'b0;
        test_reset;
        test_single;
        test_glitch;
        test_full_scan;
        test_illegal_blank;
        test_multi_none;
        test_reset_mid_track;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
